// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared funct3 encodings, MEM FSM states and exception codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    ILLEGAL  = 2'd2,
    BUS_ERR  = 2'd3
  } exc_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Brief   : Byte-lane store shift/strobe, load extract/extend, misalign check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_acc_off,
  input  logic [2:0]  i_acc_funct3,
  input  logic [63:0] i_st_data,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic        o_misalign,
  input  logic [2:0]  i_ld_off,
  input  logic [2:0]  i_ld_funct3,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_ld_data
);

  logic [63:0] w_ld_shift;

  always_comb begin
    o_wdata    = i_st_data << {i_acc_off, 3'b000};
    o_wstrb    = 8'h00;
    o_misalign = 1'b0;
    // Size lives in funct3[1:0] for both loads and stores.
    case (i_acc_funct3[1:0])
      2'b00: begin o_wstrb = 8'h01 << i_acc_off; o_misalign = 1'b0;             end
      2'b01: begin o_wstrb = 8'h03 << i_acc_off; o_misalign = i_acc_off[0];     end
      2'b10: begin o_wstrb = 8'h0F << i_acc_off; o_misalign = |i_acc_off[1:0];  end
      default: begin o_wstrb = 8'hFF;            o_misalign = |i_acc_off;       end
    endcase
  end

  always_comb begin
    w_ld_shift = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_funct3)
      LB:      o_ld_data = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
      LH:      o_ld_data = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      LW:      o_ld_data = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      LBU:     o_ld_data = {56'd0, w_ld_shift[7:0]};
      LHU:     o_ld_data = {48'd0, w_ld_shift[15:0]};
      LWU:     o_ld_data = {32'd0, w_ld_shift[31:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : RV64 MEM stage: EX->MEM handshake, dmem req/gnt/rvalid, WB result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic [63:0] i_ex_alu_result,
  input  logic [63:0] i_ex_rs2V,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_RegWrite,
  input  logic        i_ex_MemRead,
  input  logic        i_ex_MemWrite,
  input  logic [2:0]  i_ex_funct3,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [63:0] o_dmem_addr,
  output logic [63:0] o_dmem_wdata,
  output logic [7:0]  o_dmem_wstrb,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [63:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_RegWrite,
  output logic [63:0] o_wb_data,
  output logic        o_wb_exc,
  output logic [1:0]  o_wb_exc_code
);

  localparam int unsigned c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_timer_last = c_tw'(TIMEOUT - 1);

  mem_state_e        r_state;
  logic [c_tw-1:0]   r_timer;
  logic              r_req, r_we;
  logic [63:0]       r_addr, r_wdata;
  logic [7:0]        r_wstrb;
  logic [4:0]        r_rd;
  logic              r_regwrite;
  logic [2:0]        r_f3, r_off;
  logic              r_wb_valid, r_wb_rw, r_wb_exc;
  logic [4:0]        r_wb_rd;
  logic [63:0]       r_wb_data;
  exc_e              r_wb_code;

  logic [63:0] w_wdata, w_ld_data;
  logic [7:0]  w_wstrb;
  logic        w_misalign, w_is_mem, w_illegal;

  lsu_align u_lsu_align (
    .i_acc_off    (i_ex_alu_result[2:0]),
    .i_acc_funct3 (i_ex_funct3),
    .i_st_data    (i_ex_rs2V),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_misalign   (w_misalign),
    .i_ld_off     (r_off),
    .i_ld_funct3  (r_f3),
    .i_rdata      (i_dmem_rdata),
    .o_ld_data    (w_ld_data)
  );

  assign w_is_mem  = i_ex_MemRead | i_ex_MemWrite;
  assign w_illegal = (i_ex_MemRead & i_ex_MemWrite) |
                     (i_ex_MemRead & (i_ex_funct3 == 3'b111)) |
                     (i_ex_MemWrite & i_ex_funct3[2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_f3       <= '0;
      r_off      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_data  <= '0;
      r_wb_exc   <= 1'b0;
      r_wb_code  <= NONE;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_ex_valid) begin
          r_wb_rd <= i_ex_rd;
          if (!w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_rw    <= i_ex_RegWrite & (i_ex_rd != 5'd0);
            r_wb_data  <= i_ex_alu_result;
            r_wb_exc   <= 1'b0;
            r_wb_code  <= NONE;
          end else if (w_illegal || w_misalign) begin
            r_wb_valid <= 1'b1;
            r_wb_rw    <= 1'b0;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b1;
            r_wb_code  <= w_illegal ? ILLEGAL : MISALIGN;
          end else begin
            r_state    <= REQ;
            r_timer    <= '0;
            r_req      <= 1'b1;
            r_we       <= i_ex_MemWrite;
            r_addr     <= {i_ex_alu_result[63:3], 3'b000};
            r_wdata    <= i_ex_MemWrite ? w_wdata : 64'd0;
            r_wstrb    <= i_ex_MemWrite ? w_wstrb : 8'd0;
            r_rd       <= i_ex_rd;
            r_regwrite <= i_ex_RegWrite & (i_ex_rd != 5'd0);
            r_f3       <= i_ex_funct3;
            r_off      <= i_ex_alu_result[2:0];
          end
        end
        REQ: begin
          // A grant in the final allowed cycle still completes normally.
          if (i_dmem_gnt) begin
            r_req   <= 1'b0;
            r_timer <= r_timer + 1'b1;
            if (r_we) begin
              r_state    <= IDLE;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_rw    <= 1'b0;
              r_wb_data  <= '0;
              r_wb_exc   <= 1'b0;
              r_wb_code  <= NONE;
            end else begin
              r_state <= WAIT;
            end
          end else if (r_timer == c_timer_last) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_rw    <= 1'b0;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b1;
            r_wb_code  <= BUS_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT: begin
          r_wb_rd <= r_rd;
          if (i_dmem_rvalid) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_rw    <= r_regwrite;
            r_wb_data  <= w_ld_data;
            r_wb_exc   <= 1'b0;
            r_wb_code  <= NONE;
          end else if (r_timer == c_timer_last) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_rw    <= 1'b0;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b1;
            r_wb_code  <= BUS_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ex_ready    = (r_state == IDLE);
  assign o_dmem_req    = r_req;
  assign o_dmem_we     = r_we;
  assign o_dmem_addr   = r_addr;
  assign o_dmem_wdata  = r_wdata;
  assign o_dmem_wstrb  = r_wstrb;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_RegWrite = r_wb_rw;
  assign o_wb_data     = r_wb_data;
  assign o_wb_exc      = r_wb_exc;
  assign o_wb_exc_code = r_wb_code;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Directed scoreboard bench for mem_stage (TIMEOUT = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic [63:0] ex_alu_result = '0, ex_rs2V = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_RegWrite = 1'b0, ex_MemRead = 1'b0, ex_MemWrite = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        wb_valid, wb_RegWrite, wb_exc;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  wb_exc_code;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] data;
    logic        exc;
    logic [1:0]  code;
  } wb_t;

  wb_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_alu_result(ex_alu_result), .i_ex_rs2V(ex_rs2V), .i_ex_rd(ex_rd),
    .i_ex_RegWrite(ex_RegWrite), .i_ex_MemRead(ex_MemRead),
    .i_ex_MemWrite(ex_MemWrite), .i_ex_funct3(ex_funct3),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_RegWrite(wb_RegWrite),
    .o_wb_data(wb_data), .o_wb_exc(wb_exc), .o_wb_exc_code(wb_exc_code)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic [63:0] data,
                      input logic exc, input logic [1:0] code);
    wb_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.exc = exc; e.code = code;
    q.push_back(e);
  endtask

  // Drives one instruction at a negedge; the accepting posedge follows.
  task automatic issue(input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    @(negedge clk);
    chk("ex_ready_before_issue", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_alu_result = alu; ex_rs2V = rs2; ex_rd = rd;
    ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw; ex_funct3 = f3;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input int budget);
    wb_t e;
    bit  seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wb_valid) begin seen = 1'b1; break; end
    end
    n_vec++;
    assert (seen) else begin
      n_err++;
      $error("FAIL %s_wb_valid observed=0 expected=1", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      if (seen) begin
        chk({tag, "_rd"},   64'(wb_rd),       64'(e.rd));
        chk({tag, "_rw"},   64'(wb_RegWrite), 64'(e.rw));
        chk({tag, "_data"}, wb_data,          e.data);
        chk({tag, "_exc"},  64'(wb_exc),      64'(e.exc));
        chk({tag, "_code"}, 64'(wb_exc_code), 64'(e.code));
      end
    end
  endtask

  task automatic do_store(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] rs2, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_wstrb, input int delay);
    issue(addr, rs2, 5'd9, 1'b0, 1'b0, 1'b1, f3);
    push(5'd9, 1'b0, 64'd0, 1'b0, 2'd0);
    @(negedge clk);
    chk({tag, "_req"},   64'(dmem_req),   64'd1);
    chk({tag, "_we"},    64'(dmem_we),    64'd1);
    chk({tag, "_addr"},  dmem_addr,       {addr[63:3], 3'b000});
    chk({tag, "_wdata"}, dmem_wdata,      exp_wdata);
    chk({tag, "_wstrb"}, 64'(dmem_wstrb), 64'(exp_wstrb));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_req_held"}, 64'(dmem_req), 64'd1);
      chk({tag, "_addr_held"}, dmem_addr, {addr[63:3], 3'b000});
    end
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    expect_wb(tag, 1);
    chk({tag, "_req_drop"}, 64'(dmem_req), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] rdata,
                         input logic [63:0] exp_data, input logic exp_rw);
    issue(addr, 64'd0, rd, 1'b1, 1'b1, 1'b0, f3);
    push(rd, exp_rw, exp_data, 1'b0, 2'd0);
    @(negedge clk);
    chk({tag, "_req"},   64'(dmem_req),   64'd1);
    chk({tag, "_addr"},  dmem_addr,       {addr[63:3], 3'b000});
    chk({tag, "_wstrb"}, 64'(dmem_wstrb), 64'd0);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    dmem_rdata = rdata; dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    expect_wb(tag, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_req",      64'(dmem_req), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data",  wb_data,       64'd0);
    rst = 1'b1;

    // Plain ALU result passes straight through.
    issue(64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
    push(5'd5, 1'b1, 64'h1234, 1'b0, 2'd0);
    expect_wb("alu", 1);
    chk("alu_no_req", 64'(dmem_req), 64'd0);
    @(negedge clk);
    chk("alu_pulse", 64'(wb_valid), 64'd0);

    issue(64'hBEEF, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    push(5'd0, 1'b0, 64'hBEEF, 1'b0, 2'd0);
    expect_wb("alu_rd0", 1);

    do_store("sb", 64'h13, 3'b000, 64'hAB, 64'hAB00_0000, 8'h08, 2);
    chk("sb_lane", 64'(dmem_wdata[31:24]), 64'hAB);
    do_store("sh", 64'h12, 3'b001, 64'h1234_5678_9ABC_DEF0, 64'h5678_9ABC_DEF0_0000, 8'h0C, 0);
    do_store("sw", 64'h14, 3'b010, 64'hCAFE_BABE, 64'hCAFE_BABE_0000_0000, 8'hF0, 1);
    do_store("sd_gnt_last", 64'h18, 3'b011, 64'h0102_0304_0506_0708,
             64'h0102_0304_0506_0708, 8'hFF, 3);

    do_load("lb",  64'h21, 3'b000, 5'd3, 64'h0123_4567_89AB_80FF, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    do_load("lbu", 64'h21, 3'b100, 5'd3, 64'h0123_4567_89AB_80FF, 64'h80, 1'b1);
    do_load("lh",  64'h22, 3'b001, 5'd4, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
    do_load("lhu", 64'h22, 3'b101, 5'd4, 64'h0000_0000_8001_0000, 64'h8001, 1'b1);
    do_load("lw",  64'h24, 3'b010, 5'd6, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b1);
    do_load("lwu", 64'h24, 3'b110, 5'd6, 64'h8765_4321_0000_0000, 64'h8765_4321, 1'b1);
    do_load("ld_rd0", 64'h28, 3'b011, 5'd0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0);

    issue(64'h6, 64'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
    push(5'd8, 1'b0, 64'd0, 1'b1, 2'd1);
    expect_wb("lw_misalign", 1);
    chk("lw_misalign_no_req", 64'(dmem_req), 64'd0);

    issue(64'h40, 64'd0, 5'd8, 1'b1, 1'b1, 1'b1, 3'b011);
    push(5'd8, 1'b0, 64'd0, 1'b1, 2'd2);
    expect_wb("both_flags", 1);
    issue(64'h40, 64'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b111);
    push(5'd8, 1'b0, 64'd0, 1'b1, 2'd2);
    expect_wb("ld_f3_111", 1);
    issue(64'h40, 64'd0, 5'd8, 1'b0, 1'b0, 1'b1, 3'b100);
    push(5'd8, 1'b0, 64'd0, 1'b1, 2'd2);
    expect_wb("st_f3_100", 1);
    chk("illegal_no_req", 64'(dmem_req), 64'd0);

    // No grant: four REQ cycles, then BUS_ERR.
    issue(64'h48, 64'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b011);
    push(5'd10, 1'b0, 64'd0, 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_held", 64'(dmem_req), 64'd1);
      chk("to_busy", 64'(ex_ready), 64'd0);
    end
    expect_wb("req_timeout", 1);
    chk("to_ready_back", 64'(ex_ready), 64'd1);
    chk("to_req_drop", 64'(dmem_req), 64'd0);

    issue(64'h50, 64'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b011);
    push(5'd11, 1'b0, 64'd0, 1'b1, 2'd3);
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    expect_wb("wait_timeout", 5);

    // Async reset while waiting for read data.
    issue(64'h30, 64'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b011);
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(ex_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("arst_req",      64'(dmem_req), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    do_load("ld_post_rst", 64'h8, 3'b011, 5'd7, 64'hDEAD_BEEF_CAFE_F00D,
            64'hDEAD_BEEF_CAFE_F00D, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
